sr_cmd_gen: RTL

Upstream command stage for the SR flip-flop. Two raw, asynchronous, bouncy request lines (set and clear) are synchronized and debounced, then turned into press events. An arbiter issues those events as fixed-length `s`/`r` pulses that drive the SR flip-flop's `s`/`r` inputs directly. The flip-flop never sees `s=r=1`, and never sees `s` and `r` in adjacent cycles.

---
 rtl/sr_pkg.sv | 11 +
 rtl/sr_debounce_chan.sv | 46 ++++
 rtl/sr_cmd_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared types and default parameters for the SR flip-flop command stage.
// Purely declarative: no logic, no latency.
package sr_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} sr_state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR} sr_cmd_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int PULSE_LEN_DEF       = 2;

endpackage

// File: rtl/sr_debounce_chan.sv
// One request channel: 2-flop synchronizer, debounce counter, rising-edge event.
// stable follows a settled input DEBOUNCE_CYCLES+2 edges later; no backpressure.
module sr_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic stable,
  output logic evt
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= in;
      sync2    <= sync1;
      stable_d <= stable;
      // Any cycle agreeing with stable restarts the count, so short bounces never land.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign evt = stable & ~stable_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear requests arbitrated into fixed-length, never-overlapping s/r pulses.
// s/r rise DEBOUNCE_CYCLES+3 edges after a clean press; opposite requests queue in a one-deep pending slot.
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_LEN       = PULSE_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int            PW       = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE_LEN - 1);

  logic set_stable, set_evt_raw, clr_stable, clr_evt_raw;
  logic set_evt, clr_evt;

  sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_chan (
    .clk(clk), .rst(rst), .in(set_in), .stable(set_stable), .evt(set_evt_raw)
  );

  sr_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_chan (
    .clk(clk), .rst(rst), .in(clr_in), .stable(clr_stable), .evt(clr_evt_raw)
  );

  assign set_evt = set_evt_raw & set_stable;
  assign clr_evt = clr_evt_raw & clr_stable;

  sr_state_t     state, state_nxt;
  sr_cmd_t       kind, kind_nxt;
  sr_cmd_t       pending, pending_nxt, pend_upd;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          conflict_nxt;

  always_comb begin
    state_nxt    = state;
    kind_nxt     = kind;
    pending_nxt  = pending;
    pend_upd     = pending;
    pcnt_nxt     = pcnt;
    conflict_nxt = set_evt & clr_evt;

    // While busy, only the opposite command is worth remembering.
    if (state != IDLE && !(set_evt && clr_evt)) begin
      if (set_evt && kind != CMD_SET) begin
        pend_upd = CMD_SET;
      end else if (clr_evt && kind != CMD_CLR) begin
        pend_upd = CMD_CLR;
      end
    end

    case (state)
      IDLE: begin
        if (set_evt && clr_evt) begin
          state_nxt = IDLE;
        end else if (set_evt || clr_evt) begin
          state_nxt = PULSE;
          kind_nxt  = set_evt ? CMD_SET : CMD_CLR;
          pcnt_nxt  = '0;
        end else if (pending != CMD_NONE) begin
          state_nxt   = PULSE;
          kind_nxt    = pending;
          pending_nxt = CMD_NONE;
          pcnt_nxt    = '0;
        end
      end
      PULSE: begin
        pending_nxt = pend_upd;
        if (pcnt == PCNT_MAX) begin
          state_nxt = GAP;
        end else begin
          pcnt_nxt = pcnt + PW'(1);
        end
      end
      GAP: begin
        // A queued command launches straight from GAP, giving the minimum one-cycle separation.
        if (pend_upd != CMD_NONE) begin
          state_nxt   = PULSE;
          kind_nxt    = pend_upd;
          pending_nxt = CMD_NONE;
          pcnt_nxt    = '0;
        end else begin
          state_nxt   = IDLE;
          pending_nxt = CMD_NONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      kind     <= CMD_NONE;
      pending  <= CMD_NONE;
      pcnt     <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      pending  <= pending_nxt;
      pcnt     <= pcnt_nxt;
      s        <= (state_nxt == PULSE) && (kind_nxt == CMD_SET);
      r        <= (state_nxt == PULSE) && (kind_nxt == CMD_CLR);
      busy     <= (state_nxt != IDLE);
      conflict <= conflict_nxt;
    end
  end

endmodule
